// File: rtl/gate_test_pkg.sv
// Shared types and defaults for the gate self-test sequencer family.
// Vector count helper keeps port widths and loop bounds consistent.
package gate_test_pkg;

    localparam int DEF_N_IN   = 2;
    localparam int DEF_SETTLE = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int num_vectors(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Settle interval counter: counts up while enabled, loadable, with clear and
// a flag on the last cycle of the interval (cnt == SETTLE-1).
module gate_settle_timer #(
    parameter int SETTLE = 10,
    parameter int CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    // NOTE: rst is synchronous, so it lives inside the clocked branch and the
    // sensitivity list carries only the clock edge.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/gate_self_test_ctrl.sv
// Exhaustive self-test sequencer for a small combinational gate: steps every
// input vector, waits SETTLE cycles, compares against a latched truth table.
module gate_self_test_ctrl
    import gate_test_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE,
    parameter int NV     = num_vectors(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NV-1:0]   truth_table,
    output logic [N_IN-1:0] gut_in,
    input  logic            gut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t          state;
    state_t          state_nx;
    logic [NV-1:0]   latched_table;
    logic [CW-1:0]   settle_cnt;
    logic            settle_tc;
    logic            start_ok;
    logic            last_vec;
    logic            mismatch;

    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
    assign last_vec = (gut_in == N_IN'(NV - 1));
    assign mismatch = (gut_out != latched_table[gut_in]);

    // Restart the interval on every new run and as each APPLY phase ends,
    // so the counter reads 0 on entry to every APPLY.
    gate_settle_timer #(
        .SETTLE (SETTLE),
        .CW     (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok || (state == ST_APPLY && settle_tc)),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == ST_APPLY),
        .cnt      (settle_cnt),
        .tc       (settle_tc)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch forms.
        state_nx = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nx = ST_APPLY;
            ST_APPLY: if (settle_tc) state_nx = ST_CHECK;
            ST_CHECK: state_nx = last_vec ? ST_DONE : ST_APPLY;
            ST_DONE:  if (start_ok) state_nx = ST_APPLY;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // done/pass follow the DONE state one cycle later and drop on the edge
    // that accepts a restart, so a new run never shows stale results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            gut_in           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            latched_table    <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == ST_APPLY) || (state_nx == ST_CHECK);
            done  <= (state == ST_DONE) && !start;
            pass  <= (state == ST_DONE) && !start && (err_count == '0);

            if (start_ok) begin
                latched_table    <= truth_table;
                gut_in           <= '0;
                err_count        <= '0;
                first_fail_vec   <= '0;
                first_fail_valid <= 1'b0;
            end else if (state == ST_CHECK) begin
                if (mismatch) begin
                    err_count <= err_count + 1'b1;
                    if (!first_fail_valid) begin
                        first_fail_vec   <= gut_in;
                        first_fail_valid <= 1'b1;
                    end
                end
                if (!last_vec)
                    gut_in <= gut_in + 1'b1;
            end
        end
    end

endmodule
